gf180mcu_fd_sc_mcu9t5v0__pgate_seq: RTL and testbench

Power-gating sequencer for a switchable core region built from the 9-track library. The region's substrate and wells are held by filltie/endcap rows, and its VDD rail is fed through N_GRP groups of header switches. The block stages switch turn-on to limit inrush current, waits for the switch-chain acknowledge, then sequences retention-restore, domain reset and isolation release. Power-down runs the same steps in reverse. It sits in the always-on domain, one instance per gated region.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__pgate_pkg.sv | 37 +++
 rtl/gf180mcu_fd_sc_mcu9t5v0__pgate_sync.sv | 30 +++
 rtl/gf180mcu_fd_sc_mcu9t5v0__pgate_seq.sv | 172 +++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__pgate_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pgate_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__pgate_pkg
// Brief   : Shared states, defaults and counter sizing for the power-gate sequencer
// Revision: 1.0 - initial release
// ============================================================================
package gf180mcu_fd_sc_mcu9t5v0__pgate_pkg;

  localparam int C_N_GRP_DEF    = 4;
  localparam int C_STEP_CYC_DEF = 4;
  localparam int C_ACK_TO_DEF   = 64;
  localparam int C_RET_CYC_DEF  = 2;

  typedef enum logic [3:0] {
    ST_OFF        = 4'd0,
    ST_RAMP_UP    = 4'd1,
    ST_WAIT_ACK   = 4'd2,
    ST_RESTORE    = 4'd3,
    ST_REL_RST    = 4'd4,
    ST_ON         = 4'd5,
    ST_ISO_ON     = 4'd6,
    ST_SAVE       = 4'd7,
    ST_ASSERT_RST = 4'd8,
    ST_RAMP_DN    = 4'd9
  } pgate_state_t;

  // One shared counter serves every timed state, so it is sized for the longest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pgate_sync.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__pgate_sync
// Brief   : Two-flop synchronizer, asynchronous active-low reset to 0
// Revision: 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__pgate_sync (
  input  logic CLK,
  input  logic RN,
  input  logic D,
  output logic Q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= D;
      r_sync <= r_meta;
    end
  end

  assign Q = r_sync;

endmodule
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pgate_seq.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__pgate_seq
// Brief   : Staged header-switch power-up/down sequencer with retention and isolation
// Revision: 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__pgate_seq
  import gf180mcu_fd_sc_mcu9t5v0__pgate_pkg::*;
#(
  parameter int N_GRP    = C_N_GRP_DEF,
  parameter int STEP_CYC = C_STEP_CYC_DEF,
  parameter int ACK_TO   = C_ACK_TO_DEF,
  parameter int RET_CYC  = C_RET_CYC_DEF
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             PWR_REQ,
  input  logic             SW_ACK,
  output logic             PWR_ACK,
  output logic [N_GRP-1:0] SW_EN,
  output logic             ISO,
  output logic             SAVE,
  output logic             RESTORE,
  output logic             DRST_N,
  output logic             ERR
);

  localparam int CW = cnt_width(STEP_CYC, ACK_TO, RET_CYC);
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [CW-1:0] C_STEP_LAST = CW'(STEP_CYC - 1);
  localparam logic [CW-1:0] C_ACK_LAST  = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] C_RET_LAST  = CW'(RET_CYC - 1);

  pgate_state_t     r_state;
  logic [CW-1:0]    r_cnt;
  logic [N_GRP-1:0] r_sw_en;
  logic             r_pwr_ack;
  logic             r_iso;
  logic             r_save;
  logic             r_restore;
  logic             r_drst_n;
  logic             r_err;
  logic             w_ack_s;
  logic [N_GRP-1:0] w_sw_up;
  logic [N_GRP-1:0] w_sw_dn;

  gf180mcu_fd_sc_mcu9t5v0__pgate_sync u_ack_sync (
    .CLK (CLK),
    .RN  (RN),
    .D   (SW_ACK),
    .Q   (w_ack_s)
  );

  // Shifting in a 1 / shifting out keeps the enables a thermometer code every cycle.
  assign w_sw_up = (r_sw_en << 1) | N_GRP'(1);
  assign w_sw_dn = r_sw_en >> 1;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_sw_en   <= '0;
      r_pwr_ack <= 1'b0;
      r_iso     <= 1'b1;
      r_save    <= 1'b0;
      r_restore <= 1'b0;
      r_drst_n  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (PWR_REQ && !r_err) begin
            r_state <= ST_RAMP_UP;
            r_sw_en <= w_sw_up;
            r_cnt   <= '0;
          end
        end
        ST_RAMP_UP: begin
          if (r_cnt == C_STEP_LAST) begin
            r_cnt <= '0;
            if (r_sw_en[N_GRP-1]) r_state <= ST_WAIT_ACK;
            else                  r_sw_en <= w_sw_up;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        ST_WAIT_ACK: begin
          if (w_ack_s) begin
            r_state   <= ST_RESTORE;
            r_restore <= 1'b1;
            r_cnt     <= '0;
          end else if (r_cnt == C_ACK_LAST) begin
            // Timeout: retention and reset were never touched, so drop straight to ramp-down.
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_sw_en <= w_sw_dn;
            r_state <= (w_sw_dn == '0) ? ST_OFF : ST_RAMP_DN;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        ST_RESTORE: begin
          if (r_cnt == C_RET_LAST) begin
            r_restore <= 1'b0;
            r_drst_n  <= 1'b1;
            r_state   <= ST_REL_RST;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        ST_REL_RST: begin
          r_state   <= ST_ON;
          r_iso     <= 1'b0;
          r_pwr_ack <= 1'b1;
        end
        ST_ON: begin
          if (!PWR_REQ) begin
            r_state <= ST_ISO_ON;
            r_iso   <= 1'b1;
          end
        end
        ST_ISO_ON: begin
          r_state <= ST_SAVE;
          r_save  <= 1'b1;
          r_cnt   <= '0;
        end
        ST_SAVE: begin
          if (r_cnt == C_RET_LAST) begin
            r_save   <= 1'b0;
            r_drst_n <= 1'b0;
            r_state  <= ST_ASSERT_RST;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        ST_ASSERT_RST: begin
          r_cnt   <= '0;
          r_sw_en <= w_sw_dn;
          if (w_sw_dn == '0) begin
            r_state   <= ST_OFF;
            r_pwr_ack <= 1'b0;
          end else begin
            r_state <= ST_RAMP_DN;
          end
        end
        ST_RAMP_DN: begin
          if (r_cnt == C_STEP_LAST) begin
            r_cnt   <= '0;
            r_sw_en <= w_sw_dn;
            if (w_sw_dn == '0) begin
              r_state   <= ST_OFF;
              r_pwr_ack <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign PWR_ACK = r_pwr_ack;
  assign SW_EN   = r_sw_en;
  assign ISO     = r_iso;
  assign SAVE    = r_save;
  assign RESTORE = r_restore;
  assign DRST_N  = r_drst_n;
  assign ERR     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pgate_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_gf180mcu_fd_sc_mcu9t5v0__pgate_seq
// Brief   : Directed-vector bench for the power-gate sequencer (default parameters)
// Revision: 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__pgate_seq;

  logic       CLK = 1'b0;
  logic       RN = 1'b0;
  logic       PWR_REQ = 1'b0;
  logic       SW_ACK = 1'b1;
  logic       PWR_ACK;
  logic [3:0] SW_EN;
  logic       ISO;
  logic       SAVE;
  logic       RESTORE;
  logic       DRST_N;
  logic       ERR;

  int tests_run = 0;
  int tests_failed = 0;
  logic mon_therm = 1'b0;
  logic mon_rest = 1'b0;
  logic seen_rest = 1'b0;

  gf180mcu_fd_sc_mcu9t5v0__pgate_seq dut (
    .CLK     (CLK),
    .RN      (RN),
    .PWR_REQ (PWR_REQ),
    .SW_ACK  (SW_ACK),
    .PWR_ACK (PWR_ACK),
    .SW_EN   (SW_EN),
    .ISO     (ISO),
    .SAVE    (SAVE),
    .RESTORE (RESTORE),
    .DRST_N  (DRST_N),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic is_therm(input logic [3:0] v);
    logic [3:0] p;
    p = v + 4'd1;
    return (v & p) == 4'd0;
  endfunction

  always @(negedge CLK) begin
    if (mon_therm) check("therm", {31'd0, is_therm(SW_EN)}, 32'd1);
    if (mon_rest && RESTORE) seen_rest = 1'b1;
  end

  initial begin
    // Reset values
    tick(2);
    check("rst_sw_en", {28'd0, SW_EN}, 32'h0);
    check("rst_iso", {31'd0, ISO}, 32'd1);
    check("rst_drst_n", {31'd0, DRST_N}, 32'd0);
    check("rst_pwr_ack", {31'd0, PWR_ACK}, 32'd0);
    check("rst_save_restore", {30'd0, SAVE, RESTORE}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    RN = 1'b1;
    mon_therm = 1'b1;
    tick(4);

    // 1. Power-up with SW_ACK tied high
    PWR_REQ = 1'b1;
    tick(1);  check("up_t1", {28'd0, SW_EN}, 32'h1);
    tick(3);  check("up_t4", {28'd0, SW_EN}, 32'h1);
    tick(1);  check("up_t5", {28'd0, SW_EN}, 32'h3);
    tick(4);  check("up_t9", {28'd0, SW_EN}, 32'h7);
    tick(4);  check("up_t13", {28'd0, SW_EN}, 32'hF);
    tick(4);  check("up_t17_restore", {31'd0, RESTORE}, 32'd0);
    tick(1);  check("up_t18_restore", {31'd0, RESTORE}, 32'd1);
    tick(1);  check("up_t19_restore", {31'd0, RESTORE}, 32'd1);
    check("up_t19_drst", {31'd0, DRST_N}, 32'd0);
    tick(1);  check("up_t20", {28'd0, RESTORE, DRST_N, ISO, PWR_ACK}, 32'b0110);
    tick(1);  check("up_t21", {29'd0, DRST_N, ISO, PWR_ACK}, 32'b101);

    // 2. Power-down from ON
    PWR_REQ = 1'b0;
    tick(1);  check("dn_t1", {30'd0, ISO, PWR_ACK}, 32'b11);
    tick(1);  check("dn_t2_save", {31'd0, SAVE}, 32'd1);
    tick(1);  check("dn_t3_save", {31'd0, SAVE}, 32'd1);
    tick(1);  check("dn_t4", {26'd0, SAVE, DRST_N, SW_EN}, 32'h0F);
    tick(1);  check("dn_t5", {28'd0, SW_EN}, 32'h7);
    tick(4);  check("dn_t9", {28'd0, SW_EN}, 32'h3);
    tick(4);  check("dn_t13", {28'd0, SW_EN}, 32'h1);
    tick(3);  check("dn_t16_ack", {31'd0, PWR_ACK}, 32'd1);
    tick(1);  check("dn_t17", {27'd0, PWR_ACK, SW_EN}, 32'h0);

    // 3. Timeout with SW_ACK held low
    SW_ACK = 1'b0;
    tick(4);
    PWR_REQ = 1'b1;
    mon_rest = 1'b1;
    tick(17); check("to_entry", {27'd0, ERR, SW_EN}, 32'h0F);
    tick(63); check("to_e63_err", {31'd0, ERR}, 32'd0);
    tick(1);  check("to_e64", {27'd0, ERR, SW_EN}, 32'h17);
    tick(12); check("to_e76_sw", {28'd0, SW_EN}, 32'h0);
    tick(10); check("to_locked", {27'd0, ERR, SW_EN}, 32'h10);
    mon_rest = 1'b0;
    check("to_no_restore", {31'd0, seen_rest}, 32'd0);
    #2 RN = 1'b0;
    #1 check("to_rn_clear", {31'd0, ERR}, 32'd0);
    PWR_REQ = 1'b0;
    SW_ACK = 1'b1;
    tick(1);
    RN = 1'b1;
    tick(4);

    // 4. Request dropped mid ramp-up
    PWR_REQ = 1'b1;
    tick(5);  check("drop_t5", {28'd0, SW_EN}, 32'h3);
    PWR_REQ = 1'b0;
    tick(16); check("drop_on", {30'd0, ISO, PWR_ACK}, 32'b01);
    tick(1);  check("drop_iso_on", {30'd0, ISO, PWR_ACK}, 32'b11);
    tick(1);  check("drop_save", {31'd0, SAVE}, 32'd1);
    tick(15); check("drop_end", {27'd0, PWR_ACK, SW_EN}, 32'h0);

    // 5. Asynchronous reset mid ramp-up
    tick(2);
    PWR_REQ = 1'b1;
    tick(9);  check("arst_pre", {28'd0, SW_EN}, 32'h7);
    #2 RN = 1'b0;
    #1 check("arst_now", {25'd0, SW_EN, ISO, DRST_N, PWR_ACK}, 32'b0000100);
    PWR_REQ = 1'b0;
    SW_ACK = 1'b0;
    tick(1);
    RN = 1'b1;
    tick(4);

    // 6. Late acknowledge, 10 cycles after WAIT_ACK entry
    PWR_REQ = 1'b1;
    tick(17); check("late_entry", {28'd0, SW_EN}, 32'hF);
    tick(10);
    SW_ACK = 1'b1;
    tick(2);  check("late_e12", {31'd0, RESTORE}, 32'd0);
    tick(1);  check("late_e13", {30'd0, ERR, RESTORE}, 32'b01);

    mon_therm = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
